// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
//
// Shares the register file's single write port between NUM_REQ producers.
// Each cycle the first valid requester at or after the round-robin pointer is
// offered req_ready. On the handshake, its fields are captured into a
// one-entry output register that drives the rf_* port on the following cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready per-requester handshake; req_ready is combinational, one-hot or zero
//   req_addr/data/mask  per-requester write fields, requester i at slice i
//   wb_stall            blocks every grant this cycle
//   rf_write_*          registered write port towards the register file
//   rf_grant_id         index of the requester whose write is on the rf_* port
//
// Optional feature: define REGFILE_WB_X0_DROP_EN to accept writes to
// register 0 without ever asserting rf_write_enable for them.

module regfile_wb_arbiter #(
  parameter int NUM_REQ                   = 3,
  parameter int REG_NUMBER                = 32,
  parameter int REG_WIDTH                 = 32,
  parameter int REG_ADDR_WIDTH            = $clog2(REG_NUMBER),
  parameter int REG_BYTE_WRITE_MASK_WIDTH = REG_WIDTH / 8,
  parameter int REQ_ID_WIDTH              = $clog2(NUM_REQ)
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NUM_REQ-1:0]                             req_valid,
  output logic [NUM_REQ-1:0]                             req_ready,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]              req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]                   req_data,
  input  logic [NUM_REQ*REG_BYTE_WRITE_MASK_WIDTH-1:0]   req_mask,
  input  logic                                           wb_stall,
  output logic                                           rf_write_enable,
  output logic [REG_ADDR_WIDTH-1:0]                      rf_write_reg_addr,
  output logic [REG_WIDTH-1:0]                           rf_write_data,
  output logic [REG_BYTE_WRITE_MASK_WIDTH-1:0]           rf_write_byte_mask,
  output logic [REQ_ID_WIDTH-1:0]                        rf_grant_id
);

  logic [REQ_ID_WIDTH-1:0]              ptr_q, ptr_d;
  logic                                 wen_q, wen_d;
  logic [REG_ADDR_WIDTH-1:0]            addr_q, addr_d;
  logic [REG_WIDTH-1:0]                 data_q, data_d;
  logic [REG_BYTE_WRITE_MASK_WIDTH-1:0] mask_q, mask_d;
  logic [REQ_ID_WIDTH-1:0]              id_q, id_d;

  logic                                 grant_found;
  logic [REQ_ID_WIDTH-1:0]              grant_idx;
  logic [REG_ADDR_WIDTH-1:0]            sel_addr;
  logic [REG_WIDTH-1:0]                 sel_data;
  logic [REG_BYTE_WRITE_MASK_WIDTH-1:0] sel_mask;
  logic                                 handshake;
  logic                                 write_allowed;

  // Rotating priority search: offset k from the pointer, folded back into
  // 0..NUM_REQ-1 so non-power-of-two requester counts never overrun.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_addr    = '0;
    sel_data    = '0;
    sel_mask    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = REQ_ID_WIDTH'(idx);
        sel_addr    = req_addr[idx*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        sel_data    = req_data[idx*REG_WIDTH +: REG_WIDTH];
        sel_mask    = req_mask[idx*REG_BYTE_WRITE_MASK_WIDTH +: REG_BYTE_WRITE_MASK_WIDTH];
      end
    end
  end

  // rst_n gates ready so no requester sees an accept while the block is held in reset.
  assign handshake = grant_found && !wb_stall && rst_n;
  assign req_ready = handshake ? (NUM_REQ'(1) << grant_idx) : '0;

`ifdef REGFILE_WB_X0_DROP_EN
  // x0 writes are consumed from the requester but never reach the register file.
  assign write_allowed = (sel_addr != '0);
`else
  assign write_allowed = 1'b1;
`endif

  always_comb begin
    ptr_d  = ptr_q;
    wen_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    mask_d = mask_q;
    id_d   = id_q;
    if (handshake) begin
      ptr_d  = (grant_idx == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      wen_d  = write_allowed;
      addr_d = sel_addr;
      data_d = sel_data;
      mask_d = sel_mask;
      id_d   = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      id_q   <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
      mask_q <= mask_d;
      id_q   <= id_d;
    end
  end

  assign rf_write_enable    = wen_q;
  assign rf_write_reg_addr  = addr_q;
  assign rf_write_data      = data_q;
  assign rf_write_byte_mask = mask_q;
  assign rf_grant_id        = id_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*MW-1:0] req_mask;
  logic            wb_stall;
  logic            rf_write_enable;
  logic [AW-1:0]   rf_write_reg_addr;
  logic [DW-1:0]   rf_write_data;
  logic [MW-1:0]   rf_write_byte_mask;
  logic [IW-1:0]   rf_grant_id;

  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  logic [MW-1:0] m [N];

  int vectors;
  int miscompares;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};
  assign req_mask = {m[2], m[1], m[0]};

  regfile_wb_arbiter dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_addr           (req_addr),
    .req_data           (req_data),
    .req_mask           (req_mask),
    .wb_stall           (wb_stall),
    .rf_write_enable    (rf_write_enable),
    .rf_write_reg_addr  (rf_write_reg_addr),
    .rf_write_data      (rf_write_data),
    .rf_write_byte_mask (rf_write_byte_mask),
    .rf_grant_id        (rf_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_defaults();
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(10 + i);
      d[i] = 32'hA000_0000 + DW'(i);
      m[i] = MW'(1 << i);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    wb_stall    = 1'b0;
    req_valid   = '1;
    fill_defaults();

    // Reset held with every requester valid.
    tick();
    tick();
    chk("rst_ready", 64'(req_ready), 64'(3'b000));
    chk("rst_wen", 64'(rf_write_enable), 64'(0));
    chk("rst_id", 64'(rf_grant_id), 64'(0));
    chk("rst_addr", 64'(rf_write_reg_addr), 64'(0));
    chk("rst_data", 64'(rf_write_data), 64'(0));
    chk("rst_mask", 64'(rf_write_byte_mask), 64'(0));

    // Release reset: first grant to requester 0, then fair rotation 0,1,2,0,1,2.
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(req_ready), 64'(3'b001));
    for (int k = 0; k < 6; k++) begin
      chk("fair_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
      tick();
      chk("fair_wen", 64'(rf_write_enable), 64'(1));
      chk("fair_id", 64'(rf_grant_id), 64'(k % 3));
      chk("fair_data", 64'(rf_write_data), 64'(32'hA000_0000 + (k % 3)));
      chk("fair_mask", 64'(rf_write_byte_mask), 64'(1 << (k % 3)));
    end
    req_valid = '0;
    #1;
    chk("idle_ready", 64'(req_ready), 64'(3'b000));
    tick();
    chk("idle_wen", 64'(rf_write_enable), 64'(0));

    // Single write from requester 1 (pointer is back at 0).
    a[1] = 5'd5;
    d[1] = 32'hDEAD_BEEF;
    m[1] = 4'hF;
    req_valid = 3'b010;
    #1;
    chk("single_ready", 64'(req_ready), 64'(3'b010));
    tick();
    req_valid = '0;
    chk("single_wen", 64'(rf_write_enable), 64'(1));
    chk("single_addr", 64'(rf_write_reg_addr), 64'(5));
    chk("single_data", 64'(rf_write_data), 64'(32'hDEAD_BEEF));
    chk("single_mask", 64'(rf_write_byte_mask), 64'(4'hF));
    chk("single_id", 64'(rf_grant_id), 64'(1));
    tick();
    chk("single_wen_off", 64'(rf_write_enable), 64'(0));
    chk("single_addr_hold", 64'(rf_write_reg_addr), 64'(5));
    chk("single_id_hold", 64'(rf_grant_id), 64'(1));

    // Wrap: pointer at 2, requesters 0 and 2 valid -> 2 then 0.
    fill_defaults();
    req_valid = 3'b101;
    #1;
    chk("wrap_ready2", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = 3'b001;
    chk("wrap_id2", 64'(rf_grant_id), 64'(2));
    chk("wrap_addr2", 64'(rf_write_reg_addr), 64'(12));
    #1;
    chk("wrap_ready0", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    chk("wrap_id0", 64'(rf_grant_id), 64'(0));
    chk("wrap_wen0", 64'(rf_write_enable), 64'(1));

    // Stall for three cycles with everyone valid; pointer stays at 1.
    req_valid = '1;
    wb_stall  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 64'(req_ready), 64'(3'b000));
      tick();
      chk("stall_wen", 64'(rf_write_enable), 64'(0));
    end
    wb_stall = 1'b0;
    #1;
    chk("unstall_ready", 64'(req_ready), 64'(3'b010));
    tick();
    req_valid = '0;
    chk("unstall_id", 64'(rf_grant_id), 64'(1));
    chk("unstall_wen", 64'(rf_write_enable), 64'(1));
    tick();
    chk("unstall_wen_off", 64'(rf_write_enable), 64'(0));

    // x0 write from requester 0 (pointer at 2, search 2 -> 0).
    a[0] = '0;
    d[0] = 32'h1234_5678;
    req_valid = 3'b001;
    #1;
    chk("x0_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
`ifdef REGFILE_WB_X0_DROP_EN
    chk("x0_wen", 64'(rf_write_enable), 64'(0));
`else
    chk("x0_wen", 64'(rf_write_enable), 64'(1));
    chk("x0_addr", 64'(rf_write_reg_addr), 64'(0));
    chk("x0_data", 64'(rf_write_data), 64'(32'h1234_5678));
`endif
    // Pointer advanced to 1 in both builds.
    fill_defaults();
    req_valid = '1;
    #1;
    chk("x0_ptr", 64'(req_ready), 64'(3'b010));

    // Reset in the middle of a pending write.
    tick();
    chk("mid_wen", 64'(rf_write_enable), 64'(1));
    chk("mid_id", 64'(rf_grant_id), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", 64'(rf_write_enable), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(3'b000));
    chk("mid_rst_id", 64'(rf_grant_id), 64'(0));
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", 64'(req_ready), 64'(3'b001));
    tick();
    chk("mid_rel_id", 64'(rf_grant_id), 64'(0));
    chk("mid_rel_wen", 64'(rf_write_enable), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
